pe_mac_gen: RTL and testbench

- Parametrised successor to the 8-bit systolic processing element.
- Generalised operand and accumulator widths, selectable signed arithmetic, and two run-time dataflow modes: output-stationary (OS) and weight-stationary (WS).
- Adds a shift-out drain chain so accumulated results leave the array without a wide per-PE bus.
- Instanced as a 2-D grid: activations flow east, weights or partial sums flow south, drain flows along rows.

---
 rtl/pe_mac_if.sv | 34 +++
 rtl/pe_mac_gen.sv | 135 +++++++++++++
 tb/tb_pe_mac_gen.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pe_mac_if.sv
// Port bundle for one pe_mac_gen processing element: operand, partial-sum and
// drain traffic plus the per-cycle control strobes.
interface pe_mac_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic              fire;
  logic              mode;
  logic              clr;
  logic              load_w;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_w;
  logic [ACC_W-1:0]  in_ps;
  logic              cap;
  logic              shift;
  logic [ACC_W-1:0]  in_d;
  logic              out_f;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_w;
  logic [ACC_W-1:0]  out_ps;
  logic [ACC_W-1:0]  out_acc;
  logic [ACC_W-1:0]  out_d;
  logic              ovf;

  modport slave (
    input  fire, mode, clr, load_w, in_a, in_w, in_ps, cap, shift, in_d,
    output out_f, out_a, out_w, out_ps, out_acc, out_d, ovf
  );

  modport master (
    output fire, mode, clr, load_w, in_a, in_w, in_ps, cap, shift, in_d,
    input  out_f, out_a, out_w, out_ps, out_acc, out_d, ovf
  );
endinterface

// File: rtl/pe_mac_gen.sv
// Systolic MAC processing element with output-stationary / weight-stationary
// dataflow and a shift-out drain chain. Define PE_SAT_EN for saturating sums.
module pe_mac_gen #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0
) (
  input  logic     clk,
  input  logic     rst,
  pe_mac_if.slave  bus
);

  localparam int PROD_W = 2 * DATA_W;

  // Full-width product, extended to ACC_W according to operand signedness.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] w);
    logic signed [PROD_W-1:0] prod_s;
    logic        [PROD_W-1:0] prod_u;
    prod_s = PROD_W'($signed(a)) * PROD_W'($signed(w));
    prod_u = PROD_W'(a) * PROD_W'(w);
    if (SIGNED != 0) return ACC_W'(prod_s);
    else             return ACC_W'(prod_u);
  endfunction

  // Returns {saturated, sum}; the wrapping build never reports saturation.
  function automatic logic [ACC_W:0] add_acc(input logic [ACC_W-1:0] x,
                                             input logic [ACC_W-1:0] y);
    logic [ACC_W-1:0] res;
    logic             hit;
`ifdef PE_SAT_EN
    logic [ACC_W:0]   sum_u;
    sum_u = {1'b0, x} + {1'b0, y};
    res   = sum_u[ACC_W-1:0];
    hit   = 1'b0;
    if (SIGNED != 0) begin
      if ((x[ACC_W-1] == y[ACC_W-1]) && (res[ACC_W-1] != x[ACC_W-1])) begin
        hit = 1'b1;
        res = x[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (sum_u[ACC_W]) begin
      hit = 1'b1;
      res = '1;
    end
`else
    res = x + y;
    hit = 1'b0;
`endif
    return {hit, res};
  endfunction

  logic              f_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] w_p1;
  logic [DATA_W-1:0] wreg_p1;
  logic [ACC_W-1:0]  ps_p1;
  logic [ACC_W-1:0]  acc_p1;
  logic [ACC_W-1:0]  d_p1;
  logic              ovf_p1;

  logic              os_fire;
  logic              ws_fire;
  logic              ws_load;
  logic [ACC_W-1:0]  prod_os;
  logic [ACC_W-1:0]  prod_ws;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W:0]    os_res;
  logic [ACC_W:0]    ws_res;
  logic              sat_hit;

  // ---- stage p0: operand decode, multiply and accumulate ----
  always_comb begin
    os_fire  = bus.fire & ~bus.mode;
    ws_fire  = bus.fire &  bus.mode;
    ws_load  = bus.load_w & bus.mode;
    prod_os  = mul_ext(bus.in_a, bus.in_w);
    // WS multiplies by the weight held before any same-cycle reload.
    prod_ws  = mul_ext(bus.in_a, wreg_p1);
    // A capture hands the old total to the drain, so the fire restarts the sum.
    acc_base = (bus.clr | bus.cap) ? '0 : acc_p1;
    os_res   = add_acc(acc_base, prod_os);
    ws_res   = add_acc(bus.in_ps, prod_ws);
    sat_hit  = (os_fire & os_res[ACC_W]) | (ws_fire & ws_res[ACC_W]);
  end

  // ---- stage p1: registered element state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      f_p1   <= 1'b0;
      ovf_p1 <= 1'b0;
    end else begin
      f_p1 <= bus.fire;
      if (sat_hit) ovf_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_p1    <= '0;
      w_p1    <= '0;
      wreg_p1 <= '0;
      ps_p1   <= '0;
      acc_p1  <= '0;
    end else begin
      if (os_fire) begin
        acc_p1 <= os_res[ACC_W-1:0];
        a_p1   <= bus.in_a;
        w_p1   <= bus.in_w;
      end
      if (ws_fire) begin
        ps_p1 <= ws_res[ACC_W-1:0];
        a_p1  <= bus.in_a;
      end
      if (ws_load) begin
        wreg_p1 <= bus.in_w;
        w_p1    <= bus.in_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            d_p1 <= '0;
    else if (bus.cap)   d_p1 <= acc_p1;
    else if (bus.shift) d_p1 <= bus.in_d;
  end

  assign bus.out_f   = f_p1;
  assign bus.out_a   = a_p1;
  assign bus.out_w   = w_p1;
  assign bus.out_ps  = ps_p1;
  assign bus.out_acc = acc_p1;
  assign bus.out_d   = d_p1;
  assign bus.ovf     = ovf_p1;

endmodule

// File: tb/tb_pe_mac_gen.sv
// Directed bench for pe_mac_gen: OS/WS arithmetic, drain chain, reset and
// accumulator overflow in both the wrapping and PE_SAT_EN builds.
module tb_pe_mac_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  pe_mac_if #(.DATA_W(8), .ACC_W(32)) ifo ();
  pe_mac_if #(.DATA_W(8), .ACC_W(32)) ifw ();
  pe_mac_if #(.DATA_W(8), .ACC_W(32)) ifc0 ();
  pe_mac_if #(.DATA_W(8), .ACC_W(32)) ifc1 ();
  pe_mac_if #(.DATA_W(8), .ACC_W(32)) ifc2 ();
  pe_mac_if #(.DATA_W(8), .ACC_W(16)) ifv ();

  pe_mac_gen #(.DATA_W(8), .ACC_W(32), .SIGNED(0)) u_os (.clk(clk), .rst(rst), .bus(ifo));
  pe_mac_gen #(.DATA_W(8), .ACC_W(32), .SIGNED(1)) u_ws (.clk(clk), .rst(rst), .bus(ifw));
  pe_mac_gen #(.DATA_W(8), .ACC_W(32), .SIGNED(0)) u_c0 (.clk(clk), .rst(rst), .bus(ifc0));
  pe_mac_gen #(.DATA_W(8), .ACC_W(32), .SIGNED(0)) u_c1 (.clk(clk), .rst(rst), .bus(ifc1));
  pe_mac_gen #(.DATA_W(8), .ACC_W(32), .SIGNED(0)) u_c2 (.clk(clk), .rst(rst), .bus(ifc2));
  pe_mac_gen #(.DATA_W(8), .ACC_W(16), .SIGNED(0)) u_ov (.clk(clk), .rst(rst), .bus(ifv));

  // Drain chain runs west (c0) to east (c2).
  assign ifc1.in_d = ifc0.out_d;
  assign ifc2.in_d = ifc1.out_d;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  w;
    logic        clr;
    logic [31:0] exp_acc;
  } os_vec_t;

  os_vec_t os_tab[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    else n_pass++;
  endtask

  initial begin
    {ifo.fire, ifo.mode, ifo.clr, ifo.load_w, ifo.cap, ifo.shift} = '0;
    {ifo.in_a, ifo.in_w} = '0; ifo.in_ps = '0; ifo.in_d = '0;
    {ifw.fire, ifw.mode, ifw.clr, ifw.load_w, ifw.cap, ifw.shift} = '0;
    {ifw.in_a, ifw.in_w} = '0; ifw.in_ps = '0; ifw.in_d = '0;
    {ifc0.fire, ifc0.mode, ifc0.clr, ifc0.load_w, ifc0.cap, ifc0.shift} = '0;
    {ifc0.in_a, ifc0.in_w} = '0; ifc0.in_ps = '0; ifc0.in_d = '0;
    {ifc1.fire, ifc1.mode, ifc1.clr, ifc1.load_w, ifc1.cap, ifc1.shift} = '0;
    {ifc1.in_a, ifc1.in_w} = '0; ifc1.in_ps = '0;
    {ifc2.fire, ifc2.mode, ifc2.clr, ifc2.load_w, ifc2.cap, ifc2.shift} = '0;
    {ifc2.in_a, ifc2.in_w} = '0; ifc2.in_ps = '0;
    {ifv.fire, ifv.mode, ifv.clr, ifv.load_w, ifv.cap, ifv.shift} = '0;
    {ifv.in_a, ifv.in_w} = '0; ifv.in_ps = '0; ifv.in_d = '0;

    os_tab[0] = '{a: 8'd3,   w: 8'd4,   clr: 1'b0, exp_acc: 32'd12};
    os_tab[1] = '{a: 8'd5,   w: 8'd6,   clr: 1'b0, exp_acc: 32'd42};
    os_tab[2] = '{a: 8'd255, w: 8'd255, clr: 1'b0, exp_acc: 32'd65067};
    os_tab[3] = '{a: 8'd2,   w: 8'd2,   clr: 1'b1, exp_acc: 32'd4};

    repeat (2) step();
    rst = 1'b0;

    // Random activity, then reset must clear everything.
    for (int i = 0; i < 8; i++) begin
      ifo.fire = 1'($urandom); ifo.mode = 1'($urandom); ifo.load_w = 1'($urandom);
      ifo.cap = 1'($urandom); ifo.shift = 1'($urandom); ifo.clr = 1'($urandom);
      ifo.in_a = 8'($urandom) | 8'h01; ifo.in_w = 8'($urandom) | 8'h01;
      ifo.in_ps = $urandom; ifo.in_d = $urandom;
      step();
    end
    rst = 1'b1;
    repeat (2) step();
    {ifo.fire, ifo.mode, ifo.clr, ifo.load_w, ifo.cap, ifo.shift} = '0;
    rst = 1'b0;
    chk("rst_out_f",   32'(ifo.out_f), 32'd0);
    chk("rst_out_a",   32'(ifo.out_a), 32'd0);
    chk("rst_out_w",   32'(ifo.out_w), 32'd0);
    chk("rst_out_ps",  ifo.out_ps,     32'd0);
    chk("rst_out_acc", ifo.out_acc,    32'd0);
    chk("rst_out_d",   ifo.out_d,      32'd0);
    chk("rst_ovf",     32'(ifo.ovf),   32'd0);

    // OS accumulate table.
    ifo.mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifo.fire = 1'b1; ifo.in_a = os_tab[i].a; ifo.in_w = os_tab[i].w; ifo.clr = os_tab[i].clr;
      step();
      chk($sformatf("os_acc[%0d]", i), ifo.out_acc, os_tab[i].exp_acc);
      chk($sformatf("os_out_a[%0d]", i), 32'(ifo.out_a), 32'(os_tab[i].a));
      chk($sformatf("os_out_w[%0d]", i), 32'(ifo.out_w), 32'(os_tab[i].w));
    end
    chk("os_out_f_hi", 32'(ifo.out_f), 32'd1);
    // No fire: everything holds, clr ignored.
    ifo.fire = 1'b0; ifo.clr = 1'b1; ifo.in_a = 8'd9; ifo.in_w = 8'd9;
    step();
    chk("os_hold_acc", ifo.out_acc, 32'd4);
    chk("os_hold_a",   32'(ifo.out_a), 32'd2);
    chk("os_out_f_lo", 32'(ifo.out_f), 32'd0);
    chk("os_ps_hold",  ifo.out_ps, 32'd0);
    ifo.clr = 1'b0;

    // WS preload and compute, signed operands.
    ifw.mode = 1'b1; ifw.load_w = 1'b1; ifw.in_w = 8'hFD;
    step();
    chk("ws_preload_w", 32'(ifw.out_w), 32'h0000_00FD);
    ifw.load_w = 1'b0; ifw.fire = 1'b1; ifw.in_a = 8'd7; ifw.in_ps = 32'd100; ifw.in_w = 8'd0;
    step();
    chk("ws_ps_79",  ifw.out_ps, 32'd79);
    chk("ws_w_keep", 32'(ifw.out_w), 32'h0000_00FD);
    chk("ws_out_a",  32'(ifw.out_a), 32'd7);
    ifw.load_w = 1'b1; ifw.in_w = 8'd5; ifw.in_a = 8'd1; ifw.in_ps = 32'd0;
    step();
    chk("ws_old_wreg", ifw.out_ps, 32'hFFFF_FFFD);
    chk("ws_new_outw", 32'(ifw.out_w), 32'd5);
    ifw.load_w = 1'b0; ifw.in_a = 8'd2; ifw.in_ps = 32'd0;
    step();
    chk("ws_wreg_5", ifw.out_ps, 32'd10);
    chk("ws_acc_hold", ifw.out_acc, 32'd0);
    // Mode change to OS keeps out_ps, accumulates signed.
    ifw.mode = 1'b0; ifw.in_a = 8'd2; ifw.in_w = 8'd3;
    step();
    chk("mode_os_acc", ifw.out_acc, 32'd6);
    chk("mode_ps_keep", ifw.out_ps, 32'd10);
    ifw.in_a = 8'hFF; ifw.in_w = 8'd3;
    step();
    chk("os_signed_acc", ifw.out_acc, 32'd3);
    ifw.fire = 1'b0;

    // Drain: load 10/20/30, capture, shift east.
    ifc0.fire = 1'b1; ifc0.clr = 1'b1; ifc0.in_a = 8'd10; ifc0.in_w = 8'd1;
    ifc1.fire = 1'b1; ifc1.clr = 1'b1; ifc1.in_a = 8'd20; ifc1.in_w = 8'd1;
    ifc2.fire = 1'b1; ifc2.clr = 1'b1; ifc2.in_a = 8'd30; ifc2.in_w = 8'd1;
    step();
    {ifc0.fire, ifc0.clr, ifc1.fire, ifc1.clr, ifc2.fire, ifc2.clr} = '0;
    {ifc0.cap, ifc1.cap, ifc2.cap} = 3'b111;
    step();
    chk("drain_0", ifc2.out_d, 32'd30);
    {ifc0.cap, ifc1.cap, ifc2.cap} = 3'b000;
    {ifc0.shift, ifc1.shift, ifc2.shift} = 3'b111;
    step();
    chk("drain_1", ifc2.out_d, 32'd20);
    step();
    chk("drain_2", ifc2.out_d, 32'd10);
    chk("drain_west0", ifc0.out_d, 32'd0);
    {ifc0.shift, ifc1.shift, ifc2.shift} = 3'b000;
    // cap+fire on c0; cap beats shift on c1; c2 holds.
    ifc0.cap = 1'b1; ifc0.fire = 1'b1; ifc0.in_a = 8'd2; ifc0.in_w = 8'd3;
    ifc1.cap = 1'b1; ifc1.shift = 1'b1;
    step();
    chk("capfire_d",   ifc0.out_d,   32'd10);
    chk("capfire_acc", ifc0.out_acc, 32'd6);
    chk("cap_prio",    ifc1.out_d,   32'd20);
    chk("drain_hold",  ifc2.out_d,   32'd10);
    {ifc0.cap, ifc0.fire, ifc1.cap, ifc1.shift} = '0;

    // Overflow, ACC_W=16 unsigned.
    ifv.fire = 1'b1; ifv.in_a = 8'd255; ifv.in_w = 8'd255;
    step();
    chk("ovf_first_acc", 32'(ifv.out_acc), 32'd65025);
    chk("ovf_first_flag", 32'(ifv.ovf), 32'd0);
    step();
`ifdef PE_SAT_EN
    chk("ovf_acc", 32'(ifv.out_acc), 32'd65535);
    chk("ovf_flag", 32'(ifv.ovf), 32'd1);
`else
    chk("ovf_acc", 32'(ifv.out_acc), 32'd64514);
    chk("ovf_flag", 32'(ifv.ovf), 32'd0);
`endif
    ifv.fire = 1'b0;
    repeat (3) step();
`ifdef PE_SAT_EN
    chk("ovf_sticky", 32'(ifv.ovf), 32'd1);
`else
    chk("ovf_sticky", 32'(ifv.ovf), 32'd0);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ovf_rst", 32'(ifv.ovf), 32'd0);
    chk("ovf_rst_acc", 32'(ifv.out_acc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
